// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer that borrows the shared EX-stage ALU
// for WIDTH cycles per operation and deposits the result in HI/LO.
module alu_muldiv_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_NOP = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_data_1,
  output logic [WIDTH-1:0] alu_data_2,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] w_hi_q, w_hi_d;
  logic [WIDTH-1:0] w_lo_q, w_lo_d;
  logic [WIDTH-1:0] w_b_q, w_b_d;
  logic             w_div_q, w_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_shift;
  logic             carry;
  logic             load;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    w_hi_d     = w_hi_q;
    w_lo_d     = w_lo_q;
    w_b_d      = w_b_q;
    w_div_d    = w_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    load       = 1'b0;
    alu_op     = OP_NOP;
    alu_data_1 = '0;
    alu_data_2 = '0;
    rem_shift  = {w_hi_q[WIDTH-2:0], w_lo_q[WIDTH-1]};
    // A wrapped add result is smaller than either addend: that is the carry out.
    carry      = (alu_result < w_hi_q);

    case (state_q)
      S_IDLE: load = start;
      S_RUN: begin
        if (w_div_q) begin
          alu_op     = OP_SUB;
          alu_data_1 = rem_shift;
          alu_data_2 = w_b_q;
          // A set w_hi MSB means the shifted remainder overflowed WIDTH bits,
          // so it certainly exceeds the divisor; alu_result holds the low bits.
          if (w_hi_q[WIDTH-1] || (rem_shift >= w_b_q)) begin
            w_hi_d = alu_result;
            w_lo_d = {w_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            w_hi_d = rem_shift;
            w_lo_d = {w_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          alu_op     = OP_ADD;
          alu_data_1 = w_hi_q;
          alu_data_2 = w_lo_q[0] ? w_b_q : '0;
          w_hi_d     = {carry, alu_result[WIDTH-1:1]};
          w_lo_d     = {alu_result[0], w_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (count_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          hi_d    = w_hi_d;
          lo_d    = w_lo_d;
        end
      end
      S_DONE: begin
        if (start && !flush) load = 1'b1;
        else                 state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_RUN;
      count_d = '0;
      w_hi_d  = '0;
      w_lo_d  = is_div ? op_a : op_b;
      w_b_d   = is_div ? op_b : op_a;
      w_div_d = is_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      w_hi_q  <= '0;
      w_lo_q  <= '0;
      w_b_q   <= '0;
      w_div_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      w_hi_q  <= w_hi_d;
      w_lo_q  <= w_lo_d;
      w_b_q   <= w_b_d;
      w_div_q <= w_div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and random MULTU/DIVU operations against an arithmetic reference,
// with a simple ALU model closing the loop around the sequencer.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic [31:0] alu_result;
  logic [31:0] alu_data_1;
  logic [31:0] alu_data_2;
  logic [3:0]  alu_op;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_div(is_div),
    .op_a(op_a), .op_b(op_b), .flush(flush), .alu_result(alu_result),
    .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_op(alu_op),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Shared ALU: only add/sub are exercised; NOP drives zero.
  always_comb begin
    case (alu_op)
      4'b0001: alu_result = alu_data_1 + alu_data_2;
      4'b0010: alu_result = alu_data_1 - alu_data_2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    if (!d) begin
      p  = {32'd0, a} * {32'd0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 0) begin
      rh = a;
      rl = 32'hFFFF_FFFF;
    end else begin
      rh = a % b;
      rl = a / b;
    end
  endtask

  // Present a request on a falling edge; returns on the falling edge after E0.
  task automatic launch(input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_div = d; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the falling edge after E0; returns on the falling edge where done is seen.
  task automatic wait_done(input string tag, input logic d, input int pulse_at,
                           output int lat);
    int busy_n = 0;
    int bad_op = 0;
    int bad_hold = 0;
    logic [3:0] exp_op;
    exp_op = d ? 4'b0010 : 4'b0001;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (busy && alu_op !== exp_op) bad_op++;
      if (hi !== cur_hi || lo !== cur_lo) bad_hold++;
      if (lat == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    chk({tag, "_alu_op"}, 64'(bad_op), 64'd0);
    chk({tag, "_hilo_stable"}, 64'(bad_hold), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at);
    logic [31:0] eh, el;
    int lat;
    ref_op(d, a, b, eh, el);
    launch(d, a, b);
    wait_done(tag, d, pulse_at, lat);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic rd;
    int lat;
    int extra_done;

    // reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_alu_data", {alu_data_1, alu_data_2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op("mul_6x7", 1'b0, 32'd6, 32'd7, -1);
    @(negedge clk);
    chk("done_pulse_one_cycle", 64'(done), 64'd0);
    chk("idle_alu_op", 64'(alu_op), 64'd0);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
    run_op("div_msb", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1);
    run_op("div_by_zero", 1'b1, 32'd5, 32'd0, -1);

    // back-to-back: start held on the done cycle, new op enters RUN directly
    launch(1'b0, 32'd12, 32'd12);
    wait_done("b2b_first", 1'b0, -1, lat);
    cur_hi = 32'd0; cur_lo = 32'd144;
    start = 1'b1; is_div = 1'b0; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle", 64'(busy), 64'd1);
    wait_done("b2b_second", 1'b0, 15, lat);
    chk("b2b_lo", 64'(lo), 64'd9);
    cur_lo = 32'd9;
    // start pulsed mid-RUN above must not produce another done
    extra_done = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("midrun_start_ignored", 64'(extra_done), 64'd0);

    // flush at count=10
    launch(1'b1, 32'd1000, 32'd3);
    for (int i = 1; i < 11; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    extra_done = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("flush_no_done", 64'(extra_done), 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {cur_hi, cur_lo});

    // flush and start together on the done cycle: flush wins
    launch(1'b0, 32'd5, 32'd5);
    wait_done("flush_done", 1'b0, -1, lat);
    cur_hi = 32'd0; cur_lo = 32'd25;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", 64'(busy), 64'd0);

    // random operations
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      run_op(rd ? "rand_div" : "rand_mul", rd, ra, rb, -1);
    end

    // asynchronous reset mid-RUN
    launch(1'b0, 32'd77, 32'd88);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd0);
    chk("arst_alu_data", {alu_data_1, alu_data_2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_hi = '0; cur_lo = '0;
    run_op("post_reset", 1'b1, 32'd100, 32'd7, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
